// File: rtl/dp_ram_clr_if.sv
// Port-A / port-B bus bundle for dp_ram_clr.
// The RAM is the slave; the CPU-side (or bench) driver is the master.
interface dp_ram_clr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              ready;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              collision;

  modport master (
    input  ready, a_rdata, b_rdata, collision,
    output a_we, a_addr, a_wdata, b_we, b_addr, b_wdata
  );

  modport slave (
    output ready, a_rdata, b_rdata, collision,
    input  a_we, a_addr, a_wdata, b_we, b_addr, b_wdata
  );
endinterface

// File: rtl/dp_ram_clr.sv
// Dual-port synchronous RAM with selectable port-A read mode and collision flag.
// Define RAM_CLEAR_EN to build the post-reset clear sequencer (CLEAR_VAL fill).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | sequencer writes CLEAR_VAL to mem[clr_cnt]; ports ignored
//   ST_RUN   | normal dual-port operation, ready=1
module dp_ram_clr #(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 16,
  parameter int                A_WRITE_FIRST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL     = '0
) (
  input logic         clk,
  input logic         reset,
  dp_ram_clr_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_q;
  logic              live;
  logic              same_addr;
  logic              a_wr;
  logic              b_wr;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic              collision_q;

`ifdef RAM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;
  logic              clr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The counter parks on the top address instead of wrapping.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    clr_last  = (clr_cnt_q == {ADDR_W{1'b1}});
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_last) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign clr_addr = clr_cnt_q;
  assign ready_q  = (state_q == ST_RUN);
`else
  logic unused_clear_val;

  always_ff @(posedge clk) begin
    ready_q <= ~reset;
  end

  assign clr_we           = 1'b0;
  assign clr_addr         = '0;
  assign unused_clear_val = ^CLEAR_VAL;
`endif

  // Reset never modifies the array, so a preloaded image survives it.
  assign live      = ready_q & ~reset;
  assign same_addr = (bus.a_addr == bus.b_addr);
  assign a_wr      = live & bus.a_we;
  assign b_wr      = live & bus.b_we & ~(bus.a_we & same_addr);

  always_ff @(posedge clk) begin
    if (clr_we && !reset) begin
      mem[clr_addr] <= CLEAR_VAL;
    end
    if (a_wr) begin
      mem[bus.a_addr] <= bus.a_wdata;
    end
    if (b_wr) begin
      mem[bus.b_addr] <= bus.b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !ready_q) begin
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      if ((A_WRITE_FIRST != 0) && bus.a_we) begin
        a_rdata_q <= bus.a_wdata;
      end else begin
        a_rdata_q <= mem[bus.a_addr];
      end
      b_rdata_q   <= mem[bus.b_addr];
      collision_q <= bus.a_we & bus.b_we & same_addr;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_dp_ram_clr.sv
// Randomised + directed bench for dp_ram_clr against an array-based reference model.
// Two instances share stimulus: one write-first, one read-first on port A.
module tb_dp_ram_clr;

  localparam int          DW = 16;
  localparam int          AW = 4;
  localparam int          NW = 1 << AW;
  localparam logic [15:0] CV = 16'hA5A5;
`ifdef RAM_CLEAR_EN
  localparam int CLR_CYCLES = NW;
`else
  localparam int CLR_CYCLES = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  dp_ram_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  dp_ram_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus_rf ();

  assign bus_rf.a_we    = bus.a_we;
  assign bus_rf.a_addr  = bus.a_addr;
  assign bus_rf.a_wdata = bus.a_wdata;
  assign bus_rf.b_we    = bus.b_we;
  assign bus_rf.b_addr  = bus.b_addr;
  assign bus_rf.b_wdata = bus.b_wdata;

  dp_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .A_WRITE_FIRST(1), .CLEAR_VAL(CV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dp_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .A_WRITE_FIRST(0), .CLEAR_VAL(CV)) dut_rf (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rf)
  );

  // Reference model: word array, knowledge flags, expected readiness.
  logic [15:0] m [NW];
  bit          known [NW];
  bit          exp_ready = 1'b0;
  int          since = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic awe, input int aa, input logic [15:0] ad,
                       input logic bwe, input int ba, input logic [15:0] bd);
    bus.a_we    = awe;
    bus.a_addr  = AW'(aa);
    bus.a_wdata = ad;
    bus.b_we    = bwe;
    bus.b_addr  = AW'(ba);
    bus.b_wdata = bd;
  endtask

  task automatic do_cycle(input string tag);
    logic [15:0] ea_wf, ea_rf, eb;
    logic        ec;
    bit          ka_wf, ka_rf, kb;
    int          aa, ba;
    @(posedge clk);
    #1;
    aa = int'(bus.a_addr);
    ba = int'(bus.b_addr);
    ea_wf = '0; ea_rf = '0; eb = '0; ec = 1'b0;
    ka_wf = 1'b1; ka_rf = 1'b1; kb = 1'b1;
    if (reset) begin
      since     = 0;
      exp_ready = 1'b0;
    end else begin
      if (exp_ready) begin
        ea_rf = m[aa];
        ka_rf = known[aa];
        eb    = m[ba];
        kb    = known[ba];
        ea_wf = bus.a_we ? bus.a_wdata : m[aa];
        ka_wf = bus.a_we ? 1'b1 : known[aa];
        ec    = bus.a_we && bus.b_we && (aa == ba);
        if (bus.b_we && !ec) begin
          m[ba] = bus.b_wdata;
          known[ba] = 1'b1;
        end
        if (bus.a_we) begin
          m[aa] = bus.a_wdata;
          known[aa] = 1'b1;
        end
      end
      since++;
      if (!exp_ready && since >= CLR_CYCLES) begin
        exp_ready = 1'b1;
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < NW; i++) begin
          m[i] = CV;
          known[i] = 1'b1;
        end
`endif
      end
    end
    check({tag, " ready"}, 32'(bus.ready), 32'(exp_ready));
    check({tag, " ready_rf"}, 32'(bus_rf.ready), 32'(exp_ready));
    check({tag, " collision"}, 32'(bus.collision), 32'(ec));
    if (ka_wf) check({tag, " a_rdata_wf"}, 32'(bus.a_rdata), 32'(ea_wf));
    if (ka_rf) check({tag, " a_rdata_rf"}, 32'(bus_rf.a_rdata), 32'(ea_rf));
    if (kb)    check({tag, " b_rdata"}, 32'(bus.b_rdata), 32'(eb));
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      m[i] = '0;
      known[i] = 1'b0;
    end
    drive(1'b0, 0, 16'h0, 1'b0, 0, 16'h0);
`ifdef RAM_CLEAR_EN
    drive(1'b1, 2, 16'h7777, 1'b0, 0, 16'h0);
`endif
    reset = 1'b1;
    do_cycle("reset");
    do_cycle("reset");
    reset = 1'b0;
    for (int i = 0; i < 4 * NW && !exp_ready; i++) do_cycle("clear");
    drive(1'b0, 0, 16'h0, 1'b0, 0, 16'h0);

`ifdef RAM_CLEAR_EN
    for (int i = 0; i < NW; i++) begin
      drive(1'b0, i, 16'h0, 1'b0, NW - 1 - i, 16'h0);
      do_cycle("clrread");
    end
`else
    for (int i = 0; i < NW; i++) begin
      drive(1'b1, i, 16'($urandom), 1'b0, int'($urandom_range(NW - 1)), 16'h0);
      do_cycle("fill");
    end
`endif

    // Reset partway through the clear sequence (7 words written).
    reset = 1'b1;
    do_cycle("rst1");
    reset = 1'b0;
    for (int i = 0; i < 7; i++) do_cycle("mid");
    reset = 1'b1;
    do_cycle("rst2");
    reset = 1'b0;
    for (int i = 0; i < 4 * NW && !exp_ready; i++) do_cycle("reclear");
    check("ready_after_reclear", 32'(bus.ready), 32'd1);
    for (int i = 0; i < NW; i++) begin
      drive(1'b0, i, 16'h0, 1'b0, i, 16'h0);
      do_cycle("reread");
    end

    drive(1'b1, 3, 16'h1111, 1'b0, 0, 16'h0);
    do_cycle("mode_pre");
    drive(1'b1, 3, 16'h2222, 1'b0, 0, 16'h0);
    do_cycle("mode_wr");
    check("mode_wf", 32'(bus.a_rdata), 32'h2222);
    check("mode_rf", 32'(bus_rf.a_rdata), 32'h1111);
    drive(1'b0, 3, 16'h0, 1'b0, 3, 16'h0);
    do_cycle("mode_rd");
    check("mode_rd_rf", 32'(bus_rf.a_rdata), 32'h2222);

    drive(1'b0, 0, 16'h0, 1'b1, 5, 16'h0000);
    do_cycle("xp_pre");
    drive(1'b1, 5, 16'hBEEF, 1'b0, 5, 16'h0);
    do_cycle("xp_wr");
    check("xp_old", 32'(bus.b_rdata), 32'h0000);
    drive(1'b0, 0, 16'h0, 1'b0, 5, 16'h0);
    do_cycle("xp_rd");
    check("xp_new", 32'(bus.b_rdata), 32'hBEEF);

    drive(1'b1, 9, 16'h0001, 1'b1, 9, 16'h0002);
    do_cycle("coll_wr");
    check("coll_hi", 32'(bus.collision), 32'd1);
    drive(1'b0, 9, 16'h0, 1'b0, 9, 16'h0);
    do_cycle("coll_rd");
    check("coll_lo", 32'(bus.collision), 32'd0);
    check("coll_mem", 32'(bus.b_rdata), 32'h0001);

    for (int i = 0; i < 400; i++) begin
      int aa, ba;
      aa = int'($urandom_range(NW - 1));
      ba = ($urandom_range(3) == 0) ? aa : int'($urandom_range(NW - 1));
      drive(1'($urandom), aa, 16'($urandom), 1'($urandom), ba, 16'($urandom));
      reset = ($urandom_range(99) == 0);
      do_cycle("rand");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
